// File: rtl/fetch_pkg.sv
// Shared types and geometry helpers for the instruction fetch responder.
package fetch_pkg;

    typedef enum logic [1:0] {FS_IDLE, FS_REQ, FS_FILL} fetch_state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words * 4);
    endfunction

    function automatic int idx_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_words);
        return addr_w - off_w(line_words);
    endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// One-line word buffer: single synchronous write port, combinational read port.
module fetch_line_buf #(
    parameter int XLEN       = 32,
    parameter int LINE_WORDS = 4,
    localparam int IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [XLEN-1:0]  rdata_o
);

    logic [XLEN-1:0] mem_q [LINE_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/fetch_responder.sv
// Instruction read-channel responder: zero-latency hits from a one-line buffer,
// stalls the core while the line is refilled from backing memory.
module fetch_responder
    import fetch_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [ADDR_W-1:0] RCH1_ADDR,
    output logic [XLEN-1:0]   RCH1_DATA,
    output logic              CORE_STALL,
    output logic              RCH1_FAULT,
    input  logic              INVALIDATE,
    output logic              MEM_REQ_VALID,
    input  logic              MEM_REQ_READY,
    output logic [ADDR_W-1:0] MEM_REQ_ADDR,
    input  logic              MEM_RESP_VALID,
    input  logic [XLEN-1:0]   MEM_RESP_DATA,
    output logic [1:0]        DBG_STATE
);

    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(LINE_WORDS);
    localparam int TAG_W = tag_w(ADDR_W, LINE_WORDS);

    fetch_state_t     state_q;
    logic             line_valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] miss_tag_q;
    logic [IDX_W-1:0] beat_cnt_q;
    logic [IDX_W-1:0] beat_cnt_d;
    logic             inv_pend_q;

    logic             is_idle;
    logic             fault;
    logic             hit;
    logic             last_beat;
    logic [TAG_W-1:0] addr_tag;
    logic [XLEN-1:0]  buf_rdata;

    assign addr_tag   = RCH1_ADDR[ADDR_W-1:OFF_W];
    assign is_idle    = (state_q == FS_IDLE);
    // Gated by RSTN so a misaligned PC cannot raise a fault while held in reset.
    assign fault      = RSTN && is_idle && (RCH1_ADDR[1:0] != 2'b00);
    assign hit        = line_valid_q && (tag_q == addr_tag);
    assign beat_cnt_d = beat_cnt_q + IDX_W'(1);
    assign last_beat  = (beat_cnt_q == IDX_W'(LINE_WORDS - 1));

    fetch_line_buf #(
        .XLEN       (XLEN),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buf (
        .clk_i   (CLK),
        .we_i    ((state_q == FS_FILL) && MEM_RESP_VALID),
        .widx_i  (beat_cnt_q),
        .wdata_i (MEM_RESP_DATA),
        .ridx_i  (RCH1_ADDR[OFF_W-1:2]),
        .rdata_o (buf_rdata)
    );

    assign CORE_STALL    = !is_idle || (!hit && !fault);
    assign RCH1_FAULT    = fault;
    assign RCH1_DATA     = (is_idle && hit && !fault) ? buf_rdata : '0;
    assign MEM_REQ_VALID = (state_q == FS_REQ);
    assign MEM_REQ_ADDR  = {miss_tag_q, {OFF_W{1'b0}}};
    assign DBG_STATE     = state_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= FS_IDLE;
            line_valid_q <= 1'b0;
            tag_q        <= '0;
            miss_tag_q   <= '0;
            beat_cnt_q   <= '0;
            inv_pend_q   <= 1'b0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (INVALIDATE) begin
                        line_valid_q <= 1'b0;
                    end
                    if (!fault && !hit) begin
                        miss_tag_q   <= addr_tag;
                        line_valid_q <= 1'b0;
                        state_q      <= FS_REQ;
                    end
                end
                FS_REQ: begin
                    if (INVALIDATE) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (MEM_REQ_READY) begin
                        beat_cnt_q <= '0;
                        state_q    <= FS_FILL;
                    end
                end
                FS_FILL: begin
                    if (INVALIDATE) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (MEM_RESP_VALID) begin
                        beat_cnt_q <= beat_cnt_d;
                        // An invalidate seen at any point of the refill leaves the line invalid.
                        if (last_beat) begin
                            tag_q        <= miss_tag_q;
                            line_valid_q <= !inv_pend_q && !INVALIDATE;
                            inv_pend_q   <= 1'b0;
                            state_q      <= FS_IDLE;
                        end
                    end
                end
                default: state_q <= FS_IDLE;
            endcase
        end
    end

    resp_outside_fill_a: assert property (
        @(posedge CLK) disable iff (!RSTN) MEM_RESP_VALID |-> (state_q == FS_FILL)
    );

endmodule
